// File: rtl/axil_cfg_seq_pkg.sv
// Shared types and constants for the AXI-Lite configuration sequencer.
package axil_cfg_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/axil_cfg_seq_wdog.sv
// Saturating transaction watchdog: counts enabled cycles since the last clear
// and flags once the limit is reached. A limit of 0 never expires.
module axil_cfg_seq_wdog #(
  parameter int LIMIT = 1024,
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIMIT_W)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (LIMIT != 0) && (r_count == LIMIT_W);

endmodule

// File: rtl/axil_cfg_seq.sv
// Single-outstanding AXI-Lite master: one command in, one legal AXI-Lite
// transaction out, one response back, with a slow-slave watchdog flag.
module axil_cfg_seq
  import axil_cfg_seq_pkg::*;
#(
  parameter int AXIL_ADDR_WIDTH = 24,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int TIMEOUT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_cmd_valid,
  output logic                       s_cmd_ready,
  input  logic                       s_cmd_we,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_cmd_addr,
  input  logic [AXIL_DATA_WIDTH-1:0] s_cmd_data,
  input  logic [AXIL_STRB_WIDTH-1:0] s_cmd_strb,
  output logic                       m_rsp_valid,
  input  logic                       m_rsp_ready,
  output logic [AXIL_DATA_WIDTH-1:0] m_rsp_data,
  output logic [1:0]                 m_rsp_resp,
  output logic                       m_rsp_timeout,
  output logic                       busy,
  output logic [AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]                 m_axil_awprot,
  output logic                       m_axil_awvalid,
  input  logic                       m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0] m_axil_wdata,
  output logic [AXIL_STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                       m_axil_wvalid,
  input  logic                       m_axil_wready,
  input  logic [1:0]                 m_axil_bresp,
  input  logic                       m_axil_bvalid,
  output logic                       m_axil_bready,
  output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]                 m_axil_arprot,
  output logic                       m_axil_arvalid,
  input  logic                       m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]                 m_axil_rresp,
  input  logic                       m_axil_rvalid,
  output logic                       m_axil_rready
);

  state_t                     r_state;
  logic [AXIL_ADDR_WIDTH-1:0] r_addr;
  logic [AXIL_DATA_WIDTH-1:0] r_wdata;
  logic [AXIL_STRB_WIDTH-1:0] r_wstrb;
  logic                       r_awvalid;
  logic                       r_wvalid;
  logic [AXIL_DATA_WIDTH-1:0] r_rsp_data;
  logic [1:0]                 r_rsp_resp;

  logic w_accept;
  logic w_wdog_en;
  logic w_expired;
  logic w_aw_done;
  logic w_w_done;

  assign w_accept  = (r_state == IDLE) && s_cmd_valid;
  assign w_wdog_en = r_state inside {WR, WR_RESP, RD_ADDR, RD_DATA};
  // A channel counts as done if it already handshook or handshakes this cycle.
  assign w_aw_done = !r_awvalid || m_axil_awready;
  assign w_w_done  = !r_wvalid  || m_axil_wready;

  axil_cfg_seq_wdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (TIMEOUT_WIDTH)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_accept),
    .i_en      (w_wdog_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_resp <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_cmd_valid) begin
            r_addr <= s_cmd_addr;
            if (s_cmd_we == OP_WR) begin
              r_wdata   <= s_cmd_data;
              r_wstrb   <= s_cmd_strb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR;
            end else begin
              r_state <= RD_ADDR;
            end
          end
        end
        WR: begin
          if (m_axil_awready) r_awvalid <= 1'b0;
          if (m_axil_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) r_state <= WR_RESP;
        end
        WR_RESP: begin
          if (m_axil_bvalid) begin
            r_rsp_resp <= m_axil_bresp;
            r_rsp_data <= '0;
            r_state    <= RSP;
          end
        end
        RD_ADDR: begin
          if (m_axil_arready) r_state <= RD_DATA;
        end
        RD_DATA: begin
          if (m_axil_rvalid) begin
            r_rsp_data <= m_axil_rdata;
            r_rsp_resp <= m_axil_rresp;
            r_state    <= RSP;
          end
        end
        RSP: begin
          if (m_rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_cmd_ready    = (r_state == IDLE);
  assign busy           = (r_state != IDLE);
  assign m_rsp_valid    = (r_state == RSP);
  assign m_rsp_data     = r_rsp_data;
  assign m_rsp_resp     = r_rsp_resp;
  assign m_rsp_timeout  = w_expired && (r_state != IDLE);
  assign m_axil_awaddr  = r_addr;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_wstrb;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_bready  = (r_state == WR_RESP);
  assign m_axil_araddr  = r_addr;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = (r_state == RD_ADDR);
  assign m_axil_rready  = (r_state == RD_DATA);

endmodule

// File: tb/tb_axil_cfg_seq.sv
// Directed plus randomized bench for axil_cfg_seq against a phase-level
// protocol model of one command -> one AXI-Lite transaction -> one response.
module tb_axil_cfg_seq;
  import axil_cfg_seq_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_cmd_valid = 1'b0, s_cmd_ready, s_cmd_we = 1'b0;
  logic [23:0] s_cmd_addr = '0;
  logic [31:0] s_cmd_data = '0;
  logic [3:0]  s_cmd_strb = '0;
  logic        m_rsp_valid, m_rsp_ready = 1'b0, m_rsp_timeout, busy;
  logic [31:0] m_rsp_data;
  logic [1:0]  m_rsp_resp;
  logic [23:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [31:0] wdata, rdata = '0;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;

  int errors = 0;
  int checks = 0;

  // per-transaction configuration and observations
  logic        c_we;
  logic [23:0] c_addr;
  logic [31:0] c_data, c_rdata;
  logic [3:0]  c_strb;
  logic [1:0]  c_resp;
  int unsigned c_awd, c_wd, c_bd, c_ard, c_rd, c_hold;
  int unsigned last_rsp_t, last_aw_t, last_wait, b_count;
  logic        last_obs_to;

  always #5 clk = ~clk;

  axil_cfg_seq #(
    .AXIL_ADDR_WIDTH (24),
    .AXIL_DATA_WIDTH (32),
    .AXIL_STRB_WIDTH (4),
    .TIMEOUT_CYCLES  (TO),
    .TIMEOUT_WIDTH   (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_cmd_valid    (s_cmd_valid),
    .s_cmd_ready    (s_cmd_ready),
    .s_cmd_we       (s_cmd_we),
    .s_cmd_addr     (s_cmd_addr),
    .s_cmd_data     (s_cmd_data),
    .s_cmd_strb     (s_cmd_strb),
    .m_rsp_valid    (m_rsp_valid),
    .m_rsp_ready    (m_rsp_ready),
    .m_rsp_data     (m_rsp_data),
    .m_rsp_resp     (m_rsp_resp),
    .m_rsp_timeout  (m_rsp_timeout),
    .busy           (busy),
    .m_axil_awaddr  (awaddr),
    .m_axil_awprot  (awprot),
    .m_axil_awvalid (awvalid),
    .m_axil_awready (awready),
    .m_axil_wdata   (wdata),
    .m_axil_wstrb   (wstrb),
    .m_axil_wvalid  (wvalid),
    .m_axil_wready  (wready),
    .m_axil_bresp   (bresp),
    .m_axil_bvalid  (bvalid),
    .m_axil_bready  (bready),
    .m_axil_araddr  (araddr),
    .m_axil_arprot  (arprot),
    .m_axil_arvalid (arvalid),
    .m_axil_arready (arready),
    .m_axil_rdata   (rdata),
    .m_axil_rresp   (rresp),
    .m_axil_rvalid  (rvalid),
    .m_axil_rready  (rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
    m_rsp_ready = 1'b0;
  endtask

  task automatic run_txn();
    bit aw_done = 0, w_done = 0, b_done = 0, ar_done = 0, r_done = 0, rsp_done = 0;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
    bit exp_to = 0;
    int unsigned t = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, rsp_cnt = 0;
    int unsigned wait_cnt = 0;
    logic [31:0] exp_data;
    exp_data = c_we ? 32'h0 : c_rdata;
    @(negedge clk);
    slave_idle();
    s_cmd_valid = 1'b1; s_cmd_we = c_we; s_cmd_addr = c_addr;
    s_cmd_data = c_data; s_cmd_strb = c_strb;
    while (!s_cmd_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("cmd_ready_idle", s_cmd_ready, 1);
    last_wait = wait_cnt; last_aw_t = 0; last_rsp_t = 0; b_count = 0;
    @(posedge clk);
    while (!rsp_done && t < 200) begin
      @(negedge clk);
      t++;
      s_cmd_valid = 1'b0; s_cmd_we = 1'($urandom); s_cmd_data = $urandom;
      chk("cmd_ready_busy", s_cmd_ready, 0);
      chk("busy", busy, 1);
      chk("awvalid", awvalid, c_we && !aw_done);
      chk("wvalid", wvalid, c_we && !w_done);
      chk("bready", bready, c_we && aw_done && w_done && !b_done);
      chk("arvalid", arvalid, !c_we && !ar_done);
      chk("rready", rready, !c_we && ar_done && !r_done);
      chk("rsp_valid", m_rsp_valid, c_we ? b_done : r_done);
      if (awvalid) begin
        if (last_aw_t == 0) last_aw_t = t;
        chk("awaddr", awaddr, c_addr);
        chk("awprot", awprot, 0);
      end
      if (wvalid) begin
        chk("wdata", wdata, c_data);
        chk("wstrb", wstrb, c_strb);
      end
      if (arvalid) begin
        chk("araddr", araddr, c_addr);
        chk("arprot", arprot, 0);
      end
      awready = c_we && (aw_cnt >= c_awd);
      wready  = c_we && (w_cnt >= c_wd);
      bvalid  = c_we && aw_done && w_done && !b_done && (b_cnt >= c_bd);
      bresp   = bvalid ? c_resp : 2'($urandom);
      arready = !c_we && (ar_cnt >= c_ard);
      rvalid  = !c_we && ar_done && !r_done && (r_cnt >= c_rd);
      rresp   = rvalid ? c_resp : 2'($urandom);
      rdata   = rvalid ? c_rdata : $urandom;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      rsp_hs = 0;
      if (m_rsp_valid) begin
        if (rsp_cnt == 0) begin
          last_rsp_t  = t;
          exp_to      = ((t - 1) >= TO);
          last_obs_to = m_rsp_timeout;
        end
        chk("rsp_data", m_rsp_data, exp_data);
        chk("rsp_resp", m_rsp_resp, c_resp);
        chk("rsp_timeout", m_rsp_timeout, exp_to);
        m_rsp_ready = (rsp_cnt >= c_hold);
        rsp_hs = m_rsp_ready;
        rsp_cnt++;
      end else begin
        m_rsp_ready = 1'($urandom);
      end
      @(posedge clk);
      aw_done |= aw_hs; w_done |= w_hs; ar_done |= ar_hs;
      b_done |= b_hs; r_done |= r_hs; rsp_done |= rsp_hs;
      if (b_hs) b_count++;
      if (!aw_done) aw_cnt++;
      if (!w_done) w_cnt++;
      if (aw_done && w_done && !b_done) b_cnt++;
      if (!ar_done) ar_cnt++;
      if (ar_done && !r_done) r_cnt++;
    end
    chk("txn_complete", rsp_done, 1);
  endtask

  task automatic spurious();
    @(negedge clk);
    slave_idle();
    bvalid = 1'b1; rvalid = 1'b1;
    #1;
    chk("spur_bready", bready, 0);
    chk("spur_rready", rready, 0);
    chk("spur_rsp_valid", m_rsp_valid, 0);
    chk("spur_busy", busy, 0);
    @(negedge clk);
    bvalid = 1'b0; rvalid = 1'b0;
    chk("spur_idle_ready", s_cmd_ready, 1);
  endtask

  task automatic set_cmd(input logic we, input logic [23:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] rd, input logic [1:0] rsp);
    c_we = we; c_addr = a; c_data = d; c_strb = s; c_rdata = rd; c_resp = rsp;
    c_awd = 0; c_wd = 0; c_bd = 0; c_ard = 0; c_rd = 0; c_hold = 0;
  endtask

  initial begin
    int unsigned bound;
    // reset state
    #12;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rsp_valid", m_rsp_valid, 0);
    chk("rst_timeout", m_rsp_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_data", m_rsp_data, 0);
    chk("rst_awaddr", awaddr, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", s_cmd_ready, 1);

    // basic write latency
    set_cmd(1'b1, 24'h000010, 32'hDEADBEEF, 4'hF, 32'h0, OKAY);
    run_txn();
    chk("wr_aw_latency", last_aw_t, 1);
    chk("wr_rsp_latency", last_rsp_t, 3);
    chk("wr_one_b", b_count, 1);

    // read with SLVERR
    set_cmd(1'b0, 24'h000020, 32'h0, 4'h0, 32'h12345678, SLVERR);
    c_hold = 2;
    run_txn();
    chk("rd_rsp_latency", last_rsp_t, 3);

    // wready lags awready by 3 cycles
    set_cmd(1'b1, 24'h000104, 32'hA5A5_0F0F, 4'h5, 32'h0, OKAY);
    c_wd = 3;
    run_txn();
    chk("lag_one_b", b_count, 1);
    spurious();

    // slow B: watchdog fires, response otherwise normal
    set_cmd(1'b1, 24'h000200, 32'h0BAD_F00D, 4'hC, 32'h0, OKAY);
    c_bd = 20;
    run_txn();
    chk("to_flag_set", last_obs_to, 1);
    set_cmd(1'b0, 24'h000204, 32'h0, 4'h0, 32'hCAFE_0001, OKAY);
    run_txn();
    chk("to_flag_clear", last_obs_to, 0);

    // held response then back-to-back commands
    set_cmd(1'b0, 24'h000300, 32'h0, 4'h0, 32'h1111_2222, DECERR);
    c_hold = 5;
    run_txn();
    set_cmd(1'b1, 24'h000304, 32'h3333_4444, 4'h3, 32'h0, EXOKAY);
    run_txn();
    chk("b2b_accept_wait", last_wait, 0);
    set_cmd(1'b0, 24'h000308, 32'h0, 4'h0, 32'h5555_6666, OKAY);
    run_txn();
    chk("b2b_accept_wait2", last_wait, 0);

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      set_cmd(1'($urandom), 24'($urandom), $urandom, 4'($urandom), $urandom, 2'($urandom));
      c_awd = $urandom_range(0, 3);
      c_wd  = $urandom_range(0, 3);
      c_ard = $urandom_range(0, 3);
      c_bd  = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 2);
      c_rd  = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 2);
      c_hold = $urandom_range(0, 3);
      run_txn();
      if (i % 4 == 0) spurious();
    end

    // reset while waiting for B
    @(negedge clk);
    slave_idle();
    s_cmd_valid = 1'b1; s_cmd_we = 1'b1; s_cmd_addr = 24'h000400;
    s_cmd_data = 32'h7777_8888; s_cmd_strb = 4'hF;
    @(negedge clk);
    s_cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    bound = 0;
    while (!bready && bound < 10) begin
      @(negedge clk);
      bound++;
    end
    chk("rst_mid_reached_wr_resp", bready, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_awvalid", awvalid, 0);
    chk("rst_mid_wvalid", wvalid, 0);
    chk("rst_mid_bready", bready, 0);
    chk("rst_mid_arvalid", arvalid, 0);
    chk("rst_mid_rready", rready, 0);
    chk("rst_mid_rsp_valid", m_rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    slave_idle();
    bvalid = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_rel_cmd_ready", s_cmd_ready, 1);
      chk("rst_rel_no_rsp", m_rsp_valid, 0);
      chk("rst_rel_bready", bready, 0);
    end
    bvalid = 1'b0;

    // sequencer still usable after the abandoned transaction
    set_cmd(1'b0, 24'h000500, 32'h0, 4'h0, 32'h9999_AAAA, OKAY);
    run_txn();
    chk("post_rst_rd_latency", last_rsp_t, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
